// File: rtl/prefetch_fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and instruction-queue signals.
// Valid/ready: a transfer happens in a cycle where valid && ready; the response channel has valid only.
interface prefetch_fetch_unit_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [31:0]     imem_resp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr;
   logic [XLEN-1:0] instr_pc;
   logic [XLEN-1:0] instr_pcplus4;
   logic [CW-1:0]   fifo_count;

   modport master (
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  redirect_valid, redirect_pc, instr_ready,
      output imem_req_valid, imem_req_addr,
      output instr_valid, instr, instr_pc, instr_pcplus4, fifo_count
   );

   modport slave (
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output redirect_valid, redirect_pc, instr_ready,
      input  imem_req_valid, imem_req_addr,
      input  instr_valid, instr, instr_pc, instr_pcplus4, fifo_count
   );
endinterface

// File: rtl/prefetch_fetch_unit.sv
// Instruction prefetch front end: pipelined in-order fetch requests, a DEPTH-entry
// instruction FIFO, and redirect handling that drops responses to stale requests.
module prefetch_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                   clk,
   input logic                   reset,
   prefetch_fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] redirect_base;
   logic [CW-1:0]   count;
   logic [CW-1:0]   live;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   pending;
   logic [CW+1:0]   credit_used;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [31:0]     data_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic            head_valid;
   logic            req_fire;
   logic            resp_drop;
   logic            resp_keep;
   logic            pop;

   // Every outstanding request reserves a FIFO slot, so pushes can never overflow.
   always_comb begin
      credit_used   = {2'b00, count} + {2'b00, live} + {2'b00, discard};
      redirect_base = bus.redirect_pc & ~XLEN'(3);
      pending       = live + discard;
   end

   assign head_valid         = count != '0;
   assign bus.imem_req_valid = reset && !bus.redirect_valid && (credit_used < (CW+2)'(DEPTH));
   assign bus.imem_req_addr  = fetch_pc;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
   assign resp_drop          = bus.imem_resp_valid && (discard != '0);
   assign resp_keep          = bus.imem_resp_valid && (discard == '0) && (live != '0);
   assign pop                = head_valid && bus.instr_ready;

   assign bus.instr_valid   = head_valid;
   assign bus.instr         = head_valid ? data_mem[rd_ptr] : '0;
   assign bus.instr_pc      = head_valid ? pc_mem[rd_ptr] : '0;
   assign bus.instr_pcplus4 = head_valid ? pc_mem[rd_ptr] + XLEN'(4) : '0;
   assign bus.fifo_count    = count;

   always_ff @(posedge clk) begin
      if (reset && !bus.redirect_valid && resp_keep) begin
         data_mem[wr_ptr] <= bus.imem_resp_data;
         pc_mem[wr_ptr]   <= resp_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         count    <= '0;
         live     <= '0;
         discard  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else if (bus.redirect_valid) begin
         // Everything still in flight now belongs to the abandoned path.
         fetch_pc <= redirect_base;
         resp_pc  <= redirect_base;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         live     <= '0;
         discard  <= (pending == '0) ? '0 : pending - CW'(bus.imem_resp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         if (resp_keep) begin
            wr_ptr  <= wr_ptr + AW'(1);
            resp_pc <= resp_pc + XLEN'(4);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (resp_drop) begin
            discard <= discard - CW'(1);
         end
         count <= count + CW'(resp_keep) - CW'(pop);
         live  <= live + CW'(req_fire) - CW'(resp_keep);
      end
   end
endmodule

// File: doc/prefetch_fetch_unit.md
Name: prefetch_fetch_unit

Overview:
- Parametrised instruction-fetch front end; successor to the single-cycle next-PC logic (PC register, PC+4 adder, branch/jump select).
- Decouples instruction memory from the execute stage. Issues pipelined requests to an instruction memory that responds in order, and buffers returned instructions with their PC and PC+4 in a DEPTH-entry FIFO.
- Accepts branch/jump redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
- XLEN, 32, address/PC width.
- DEPTH, 4, FIFO entries and maximum in-flight requests. Power of 2, >=2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  fetch address, word aligned.
- imem_resp_valid  input  1  response data valid. In order, >=1 cycle after acceptance, no backpressure.
- imem_resp_data  input  32  instruction word.
- redirect_valid  input  1  branch/jump taken; restart fetch.
- redirect_pc  input  XLEN  new PC. Bits [1:0] are ignored and treated as 00.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  consumer pops the head.
- instr  output  32  head instruction.
- instr_pc  output  XLEN  PC of the head instruction.
- instr_pcplus4  output  XLEN  instr_pc + 4, wraps modulo 2^XLEN.
- fifo_count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- **Reset** (reset==0 at a rising edge):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty: fifo_count=0, instr_valid=0.
  - live=0, discard=0, imem_req_valid=0.
  - Outputs instr, instr_pc and instr_pcplus4 read 0.
  - Reset mid-operation drops everything; responses arriving later for pre-reset requests are ignored because live==0 and discard==0.
- **Counters:**
  - live = in-flight requests whose data will be kept.
  - discard = in-flight requests whose data will be dropped.
  - Both have width clog2(DEPTH)+1.
- **Issue rule:**
  - imem_req_valid = !redirect_valid && (fifo_count + live + discard < DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake (valid && ready): fetch_pc += 4 (wraps), live += 1.
  - The credit rule guarantees the FIFO never overflows.
- **Response rule (no redirect):**
  - If imem_resp_valid && discard>0: discard -= 1 and the data is dropped.
  - Else if imem_resp_valid && live>0: push {data, resp_pc} into the FIFO, resp_pc += 4, live -= 1.
  - A response with live==0 && discard==0 is ignored (protocol error). No state changes.
- **Pop rule:**
  - instr_valid = fifo_count>0.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed; fifo_count is unchanged.
  - Pop when empty is ignored.
- **Latency:**
  - Request accepted in cycle t, response earliest in t+1.
  - Entry is visible at the head earliest in t+2 (registered FIFO).
  - Sustained throughput is one instruction per cycle once the pipeline is full.
- **Redirect** (redirect_valid==1 in cycle r):
  - FIFO is flushed; fifo_count=0 and instr_valid=0 in r+1.
  - Any pop in cycle r is ignored.
  - fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued in cycle r.
  - discard = discard + live - (imem_resp_valid ? 1 : 0), saturating at 0. Any response in cycle r belongs to old requests and is dropped.
  - live = 0.
  - The first new request is issued in r+1, subject to the credit rule.
- **Back-to-back redirects:** each one re-applies the redirect rule; the last one wins.
- **Redirect and reset together:** reset has priority.

Test Plan:
- Reset then stream, imem_req_ready=1, 1-cycle response latency, instr_ready=1 -> requests to 0x0, 0x4, 0x8 on consecutive cycles; instr_pc 0x0, 0x4, 0x8 with instr_pcplus4 0x4, 0x8, 0xC; one instruction per cycle from cycle 3 after reset release.
- Backpressure: instr_ready=0, DEPTH=4 -> exactly 4 requests issued; fifo_count=4; imem_req_valid stays 0. Raise instr_ready for 1 cycle -> one pop, then one new request to 0x10.
- Redirect with 3 in flight (3-cycle memory latency): redirect_pc=0x100 -> next 3 responses dropped; next head has instr_pc=0x100 carrying the data returned for 0x100; no stale instruction ever appears.
- Redirect in the same cycle as a response and a pop, with redirect_pc=0x203 -> response dropped; fifo_count=0 next cycle; next fetch address 0x200.
- Wrap-around: RESET_PC=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pcplus4 of FFFF_FFFC equals 0.
- Mid-stream reset with 2 responses still arriving -> outputs cleared; late responses ignored; fetch restarts at RESET_PC.
